axi4s_uart_rx: RTL



---
 rtl/axi4s_uart_pkg.sv | 35 +++
 rtl/axi4s_uart_sync.sv | 37 +++
 rtl/axi4s_uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/axi4s_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4s_uart_pkg
//  Description : Shared definitions for the AXI4-Stream UART blocks: baud-rate
//                selection, tics-per-beat computation and the RX state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4s_uart_pkg;

    // Receiver states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Synthesis builds use the real line rate; simulation uses a fast rate so
    // frames complete in a handful of clocks.
    function automatic int used_baud_rate(input int baud_rate, input int baud_rate_sim);
`ifdef SYNTHESIS
        return baud_rate;
`else
        return baud_rate_sim;
`endif
    endfunction

    // Number of aclk cycles per serial bit.
    function automatic int tics_per_beat(input int aclk_frequency, input int baud_rate);
        return aclk_frequency / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4s_uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : axi4s_uart_sync
//  Description : N-flop synchroniser for a single asynchronous bit with a
//                configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4s_uart_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_d,
    output logic o_q
);

    // A single flop offers no metastability protection.
    if (STAGES < 2) begin : g_bad_stages
        $error("axi4s_uart_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sync <= {STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/axi4s_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : axi4s_uart_rx
//  Description : 8N1 UART receiver (LSB first) delivering single-byte
//                AXI4-Stream beats, with frame-error and overrun pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4s_uart_rx
    import axi4s_uart_pkg::*;
#(
    parameter int ACLK_FREQUENCY = 200000000,
    parameter int BAUD_RATE      = 9600,
    parameter int BAUD_RATE_SIM  = 50000000
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       uart_rxd,
    output logic       rx_byte_tvalid,
    input  logic       rx_byte_tready,
    output logic [7:0] rx_byte_tdata,
    output logic       rx_byte_tkeep,
    output logic       frame_error,
    output logic       overrun
);

    localparam int C_USED_BAUD_RATE = used_baud_rate(BAUD_RATE, BAUD_RATE_SIM);
    localparam int C_TICS_PER_BEAT  = tics_per_beat(ACLK_FREQUENCY, C_USED_BAUD_RATE);
    localparam int C_HALF           = C_TICS_PER_BEAT / 2;
    localparam int C_TIC_W          = $clog2(C_TICS_PER_BEAT);

    localparam logic [C_TIC_W-1:0] C_TIC_FULL = C_TIC_W'(C_TICS_PER_BEAT - 1);
    localparam logic [C_TIC_W-1:0] C_TIC_HALF = C_TIC_W'(C_HALF - 1);

    // Fewer than four clocks per bit leaves no room for mid-bit sampling.
    if (C_TICS_PER_BEAT < 4) begin : g_bad_tics
        $error("axi4s_uart_rx: TICS_PER_BEAT must be at least 4");
    end

    logic               w_rxd_s;
    rx_state_t          r_state,       w_state_nxt;
    logic [C_TIC_W-1:0] r_tic,         w_tic_nxt;
    logic [2:0]         r_bit,         w_bit_nxt;
    logic [7:0]         r_shift,       w_shift_nxt;
    logic               r_tvalid,      w_tvalid_nxt;
    logic [7:0]         r_tdata,       w_tdata_nxt;
    logic               r_frame_error, w_frame_error_nxt;
    logic               r_overrun,     w_overrun_nxt;
    logic               w_slot_free;

    axi4s_uart_sync #(
        .STAGES      (2),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_d     (uart_rxd),
        .o_q     (w_rxd_s)
    );

    // The output slot can accept a byte if empty or being drained this cycle.
    assign w_slot_free = !r_tvalid || rx_byte_tready;

    // Next-state, bit timing, shift register and output-register logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_tic_nxt         = r_tic;
        w_bit_nxt         = r_bit;
        w_shift_nxt       = r_shift;
        w_tvalid_nxt      = r_tvalid;
        w_tdata_nxt       = r_tdata;
        w_frame_error_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;

        // Handshake drains the slot; a byte loading below may refill it.
        if (r_tvalid && rx_byte_tready) begin
            w_tvalid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_tic_nxt   = C_TIC_HALF;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_tic == '0) begin
                    if (!w_rxd_s) begin
                        w_tic_nxt   = C_TIC_FULL;
                        w_bit_nxt   = 3'd7;
                        w_state_nxt = DATA;
                    end else begin
                        // Start bit vanished before mid-bit: treat as glitch.
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_tic_nxt = r_tic - 1'b1;
                end
            end
            DATA: begin
                if (r_tic == '0) begin
                    w_shift_nxt = {w_rxd_s, r_shift[7:1]};
                    w_tic_nxt   = C_TIC_FULL;
                    if (r_bit == 3'd0) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit - 1'b1;
                    end
                end else begin
                    w_tic_nxt = r_tic - 1'b1;
                end
            end
            STOP: begin
                if (r_tic == '0) begin
                    if (w_rxd_s) begin
                        if (w_slot_free) begin
                            w_tdata_nxt  = r_shift;
                            w_tvalid_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_error_nxt = 1'b1;
                        w_state_nxt       = BREAK;
                    end
                end else begin
                    w_tic_nxt = r_tic - 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a break reports once.
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_tic         <= '0;
            r_bit         <= 3'd0;
            r_shift       <= 8'h00;
            r_tvalid      <= 1'b0;
            r_tdata       <= 8'h00;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tic         <= w_tic_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_tvalid      <= w_tvalid_nxt;
            r_tdata       <= w_tdata_nxt;
            r_frame_error <= w_frame_error_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign rx_byte_tvalid = r_tvalid;
    assign rx_byte_tdata  = r_tdata;
    assign rx_byte_tkeep  = 1'b1;
    assign frame_error    = r_frame_error;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire
